gen_rate_ctrl: RTL and testbench

//  Registered PCIe rate controller for the packet identifier front end.

---
 rtl/gen_rate_ctrl.sv | 149 ++++++++++++++
 tb/tb_gen_rate_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/gen_rate_ctrl.sv
// PCIe rate controller: decodes the applied generation into a byte-valid mask and
// sequences every rate change through DRAIN -> SETTLE -> ACTIVE so the mask never switches mid-beat.
module gen_rate_ctrl #(
    parameter int GEN1_PIPEWIDTH = 8,
    parameter int GEN2_PIPEWIDTH = 16,
    parameter int GEN3_PIPEWIDTH = 32,
    parameter int GEN4_PIPEWIDTH = 8,
    parameter int GEN5_PIPEWIDTH = 8,
    parameter int LANES          = 16,
    parameter int N              = 64,
    parameter int SETTLE_CYCLES  = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   gen,
    input  logic         hld_pd_gen,
    output logic [N-1:0] valid,
    output logic [2:0]   cur_gen,
    output logic         w,
    output logic         busy,
    output logic         done,
    output logic         gen_err
);

    localparam int K0 = (GEN1_PIPEWIDTH / 8) * LANES;
    localparam int K1 = (GEN2_PIPEWIDTH / 8) * LANES;
    localparam int K2 = (GEN3_PIPEWIDTH / 8) * LANES;
    localparam int K3 = (GEN4_PIPEWIDTH / 8) * LANES;
    localparam int K4 = (GEN5_PIPEWIDTH / 8) * LANES;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);

    generate
        if (K0 > N || K1 > N || K2 > N || K3 > N || K4 > N) begin : g_mask_too_wide
            $error("gen_rate_ctrl: a generation needs more valid bits than N provides");
        end
        if (SETTLE_CYCLES < 1) begin : g_settle_too_short
            $error("gen_rate_ctrl: SETTLE_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_DRAIN,
        ST_SETTLE
    } state_t;

    function automatic logic [N-1:0] mask_of(input logic [2:0] g);
        int k;
        logic [N-1:0] m;
        case (g)
            3'd0:    k = K0;
            3'd1:    k = K1;
            3'd2:    k = K2;
            3'd3:    k = K3;
            default: k = K4;
        endcase
        for (int i = 0; i < N; i++) begin
            m[i] = (i < k);
        end
        return m;
    endfunction

    state_t          state_q, state_d;
    logic [2:0]      gen_q;
    logic [2:0]      target_q, target_d;
    logic [2:0]      cur_gen_q, cur_gen_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    valid_q, valid_d;
    logic            done_q, done_d;
    logic            legal_gen;

    assign legal_gen = (gen_q <= 3'd4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ACTIVE;
            gen_q     <= 3'd0;
            target_q  <= 3'd0;
            cur_gen_q <= 3'd0;
            cnt_q     <= '0;
            valid_q   <= mask_of(3'd0);
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gen_q     <= gen;
            target_q  <= target_d;
            cur_gen_q <= cur_gen_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    // A late legal request re-targets the sequence; in SETTLE it also restarts the settle window.
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        cur_gen_d = cur_gen_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        case (state_q)
            ST_ACTIVE: begin
                if (legal_gen && gen_q != cur_gen_q) begin
                    target_d = gen_q;
                    valid_d  = '0;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (legal_gen && gen_q != target_q) begin
                    target_d = gen_q;
                end
                if (!hld_pd_gen) begin
                    cnt_d   = RELOAD;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (hld_pd_gen) begin
                    state_d = ST_DRAIN;
                end else if (legal_gen && gen_q != target_q) begin
                    target_d = gen_q;
                    cnt_d    = RELOAD;
                end else if (cnt_q == '0) begin
                    cur_gen_d = target_q;
                    valid_d   = mask_of(target_q);
                    done_d    = 1'b1;
                    state_d   = ST_ACTIVE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_ACTIVE;
            end
        endcase
    end

    assign valid   = valid_q;
    assign cur_gen = cur_gen_q;
    assign done    = done_q;
    assign busy    = (state_q != ST_ACTIVE);
    assign w       = (state_q == ST_ACTIVE) && !hld_pd_gen && !rst;
    // The done cycle takes priority so the two pulses never coincide.
    assign gen_err = (state_q == ST_ACTIVE) && !legal_gen && !done_q;

endmodule

// File: tb/tb_gen_rate_ctrl.sv
// Bench for gen_rate_ctrl: directed vector table, hand-written corner sequences,
// then randomized traffic compared against a cycle-level reference model.
module tb_gen_rate_ctrl;

    localparam int SETTLE = 4;
    localparam logic [63:0] M16 = 64'h0000_0000_0000_FFFF;
    localparam logic [63:0] M32 = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] M64 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  gen = 3'd0;
    logic        hld = 1'b0;
    logic [63:0] valid;
    logic [2:0]  cur_gen;
    logic        w, busy, done, gen_err;

    int vecCount  = 0;
    int missCount = 0;

    gen_rate_ctrl #(
        .GEN1_PIPEWIDTH(8), .GEN2_PIPEWIDTH(16), .GEN3_PIPEWIDTH(32),
        .GEN4_PIPEWIDTH(8), .GEN5_PIPEWIDTH(8),
        .LANES(16), .N(64), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk(clk), .rst(rst), .gen(gen), .hld_pd_gen(hld),
        .valid(valid), .cur_gen(cur_gen), .w(w), .busy(busy),
        .done(done), .gen_err(gen_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [2:0]  g;
        logic        h;
        logic [63:0] v;
        logic [2:0]  c;
        logic        b, d, e, wr;
    } vec_t;

    vec_t tbl[13];

    // Reference model: phase 0 = running, 1 = waiting for hold release, 2 = settling
    int          mPhase, mCur, mTarget, mSettled, mGenPipe;
    logic [63:0] mValid;
    logic        mDone;

    function automatic logic [63:0] maskFor(input int g);
        int widths[5] = '{8, 16, 32, 8, 8};
        int k = (widths[g] / 8) * 16;
        logic [63:0] one = 64'd1;
        if (k >= 64) return M64;
        return (one << k) - one;
    endfunction

    task automatic modelReset();
        mPhase = 0; mCur = 0; mTarget = 0; mSettled = 0; mGenPipe = 0;
        mValid = maskFor(0); mDone = 1'b0;
    endtask

    task automatic modelStep(input logic h, input int g);
        int  s     = mGenPipe;
        bit  legal = (s <= 4);
        mDone = 1'b0;
        if (mPhase == 0) begin
            if (legal && s != mCur) begin
                mTarget = s; mPhase = 1; mValid = '0;
            end
        end else if (mPhase == 1) begin
            if (legal) mTarget = s;
            if (!h) begin
                mPhase = 2; mSettled = 0;
            end
        end else begin
            if (h) begin
                mPhase = 1;
            end else if (legal && s != mTarget) begin
                mTarget = s; mSettled = 0;
            end else if (mSettled == SETTLE - 1) begin
                mPhase = 0; mCur = mTarget; mValid = maskFor(mTarget); mDone = 1'b1;
            end else begin
                mSettled++;
            end
        end
        mGenPipe = g;
    endtask

    task automatic applyStimulus(input logic r, input logic [2:0] g, input logic h);
        @(negedge clk);
        rst = r; gen = g; hld = h;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] eV, input logic [2:0] eC,
                               input logic eB, input logic eD, input logic eE, input logic eW);
        bit bad = 0;
        vecCount++;
        if (valid !== eV)   begin $display("[TB] FAIL %s valid got %h want %h", name, valid, eV); bad = 1; end
        if (cur_gen !== eC) begin $display("[TB] FAIL %s cur_gen got %0d want %0d", name, cur_gen, eC); bad = 1; end
        if (busy !== eB)    begin $display("[TB] FAIL %s busy got %b want %b", name, busy, eB); bad = 1; end
        if (done !== eD)    begin $display("[TB] FAIL %s done got %b want %b", name, done, eD); bad = 1; end
        if (gen_err !== eE) begin $display("[TB] FAIL %s gen_err got %b want %b", name, gen_err, eE); bad = 1; end
        if (w !== eW)       begin $display("[TB] FAIL %s w got %b want %b", name, w, eW); bad = 1; end
        if (bad) missCount++;
    endtask

    task automatic checkInt(input string name, input int got, input int want);
        vecCount++;
        if (got != want) begin
            $display("[TB] FAIL %s got %0d want %0d", name, got, want);
            missCount++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired before the test completed");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int busyCycles;
        int doneCount;
        logic       rr, hh;
        logic [2:0] gg;

        tbl[0]  = '{1'b1, 3'd0, 1'b0, M16,   3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 3'd0, 1'b0, M16,   3'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 3'd2, 1'b0, M16,   3'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 3'd2, 1'b0, M16,   3'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 4; i <= 8; i++) tbl[i] = '{1'b0, 3'd2, 1'b0, 64'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 3'd2, 1'b0, M64,   3'd2, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 3'd6, 1'b0, M64,   3'd2, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 3'd2, 1'b0, M64,   3'd2, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 3'd2, 1'b0, M64,   3'd2, 1'b0, 1'b0, 1'b0, 1'b1};

        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i].r, tbl[i].g, tbl[i].h);
            checkOutput($sformatf("table%0d", i), tbl[i].v, tbl[i].c, tbl[i].b, tbl[i].d, tbl[i].e, tbl[i].wr);
        end

        // Change requested while the datapath holds: drain waits, then the settle window runs
        applyStimulus(1'b1, 3'd0, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 3'd1, 1'b1);
            if (i < 2) checkOutput("hold_pre", M16, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            else       checkOutput("hold_drain", 64'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 3'd1, 1'b0);
            checkOutput("hold_release", 64'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 3'd1, 1'b0);
        checkOutput("hold_done", M32, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 3'd1, 1'b0);
        checkOutput("hold_after", M32, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Re-target during SETTLE restarts the window and still yields a single done
        applyStimulus(1'b1, 3'd0, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b0);
        busyCycles = 0;
        doneCount  = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, (i < 4) ? 3'd1 : 3'd2, 1'b0);
            if (busy) busyCycles++;
            if (done) doneCount++;
        end
        checkInt("retarget_busy_cycles", busyCycles, 8);
        checkInt("retarget_done_count", doneCount, 1);
        checkOutput("retarget_final", M64, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of SETTLE
        applyStimulus(1'b1, 3'd0, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 3'd2, 1'b0);
        checkOutput("rst_settle", 64'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd2, 1'b0);
        checkOutput("rst_async", M16, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'd0, 1'b0);
        checkOutput("rst_discard", M16, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic against the reference model
        applyStimulus(1'b1, 3'd0, 1'b0);
        modelReset();
        @(posedge clk);
        gg = 3'd0;
        for (int i = 0; i < 3000; i++) begin
            rr = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 9) < 8) gg = 3'($urandom_range(0, 4));
                else                          gg = 3'($urandom_range(5, 7));
            end
            hh = ($urandom_range(0, 3) == 0);
            applyStimulus(rr, gg, hh);
            if (rr) modelReset();
            checkOutput("random", mValid, 3'(mCur), (mPhase != 0), mDone,
                        (mPhase == 0) && (mGenPipe > 4) && !mDone,
                        (mPhase == 0) && !hh && !rr);
            @(posedge clk);
            if (!rr) modelStep(hh, int'(gg));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
